// File: rtl/pwm_led_pkg.sv
// Shared constants for the PWM LED array: parameter range limits and
// the global brightness / period-counter width.
package pwm_led_pkg;

  localparam int unsigned CH_MIN   = 1;
  localparam int unsigned CH_MAX   = 16;
  localparam int unsigned RES_MIN  = 2;
  localparam int unsigned RES_MAX  = 16;
  localparam int unsigned BRIGHT_W = 3;
  localparam int unsigned PCNT_W   = BRIGHT_W;

endpackage

// File: rtl/pwm_led_array_if.sv
// Control/status bundle of the PWM LED array. The master drives duties,
// strobe, brightness and anode polarity; the slave returns status and LED pins.
interface pwm_led_array_if #(
  parameter int unsigned CH  = 3,
  parameter int unsigned RES = 8
);
  import pwm_led_pkg::*;

  logic                  an_i;
  logic [CH*RES-1:0]     duty_i;
  logic                  update_i;
  logic [BRIGHT_W-1:0]   brightness_i;
  logic                  busy_o;
  logic                  sync_o;
  logic                  half_o;
  logic [CH-1:0]         led_o;

  modport master (
    output an_i, duty_i, update_i, brightness_i,
    input  busy_o, sync_o, half_o, led_o
  );

  modport slave (
    input  an_i, duty_i, update_i, brightness_i,
    output busy_o, sync_o, half_o, led_o
  );

endinterface

// File: rtl/pwm_led_channel.sv
// One PWM channel: active duty register, step toward the pending duty on
// wrap edges, and the registered duty compare.
// With PWM_LED_ARRAY_FADE_EN defined the step is limited to FADE_STEP per
// period; otherwise the step covers the full range (immediate jump).
module pwm_led_channel #(
  parameter int unsigned RES       = 8,
  parameter int unsigned FADE_STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RES-1:0] cnt_i,
  input  logic           gate_i,
  input  logic           step_i,
  input  logic [RES-1:0] pending_i,
  output logic           on_o,
  output logic           done_o
);

  localparam logic [RES-1:0] DUTY_MAX = {RES{1'b1}};
`ifdef PWM_LED_ARRAY_FADE_EN
  localparam logic [RES-1:0] STEP_LIM = RES'(FADE_STEP);
`else
  // Full-range limit: the whole distance is covered on one wrap edge.
  localparam logic [RES-1:0] STEP_LIM = RES'(FADE_STEP) | DUTY_MAX;
`endif

  logic [RES-1:0] active_q;
  logic [RES-1:0] dist_c;
  logic [RES-1:0] delta_c;
  logic [RES-1:0] active_next_c;
  logic           up_c;

  // Next active duty: move toward pending by at most STEP_LIM when stepping.
  always_comb begin
    up_c          = (pending_i > active_q);
    dist_c        = up_c ? (pending_i - active_q) : (active_q - pending_i);
    delta_c       = (dist_c > STEP_LIM) ? STEP_LIM : dist_c;
    active_next_c = active_q;
    if (step_i) begin
      active_next_c = up_c ? (active_q + delta_c) : (active_q - delta_c);
    end
  end

  assign done_o = (active_next_c == pending_i);

  // Active duty register and registered compare (one clock behind the counter).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      on_o     <= 1'b0;
    end else begin
      active_q <= active_next_c;
      on_o     <= gate_i & ((active_q == DUTY_MAX) | (cnt_i < active_q));
    end
  end

endmodule

// File: rtl/pwm_led_array.sv
// PWM LED array top: period counter, brightness period counter, pending
// duty capture and busy control; per-channel compare lives in pwm_led_channel.
// Optional fading is enabled by defining PWM_LED_ARRAY_FADE_EN.
module pwm_led_array
  import pwm_led_pkg::*;
#(
  parameter int unsigned CH        = 3,
  parameter int unsigned RES       = 8,
  parameter int unsigned FADE_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  pwm_led_array_if.slave  bus
);

  logic [RES-1:0]    cnt_q;
  logic [RES-1:0]    cnt_next_c;
  logic              wrap_c;
  logic [PCNT_W-1:0] pcnt_q;
  logic              gate_c;
  logic              step_c;
  logic [CH*RES-1:0] pending_q;
  logic              busy_q;
  logic              sync_q;
  logic              half_q;
  logic [CH-1:0]     on_c;
  logic [CH-1:0]     done_c;

  assign cnt_next_c = cnt_q + RES'(1);
  assign wrap_c     = (cnt_q == {RES{1'b1}});
  assign gate_c     = (pcnt_q <= bus.brightness_i);
  assign step_c     = wrap_c & busy_q;

  // Period counter, brightness period counter and the sync/half flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      sync_q <= 1'b1;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_next_c;
      sync_q <= wrap_c;
      half_q <= cnt_next_c[RES-1];
      if (wrap_c) begin
        pcnt_q <= pcnt_q + PCNT_W'(1);
      end
    end
  end

  // Pending capture; a new strobe always wins over clearing busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else if (bus.update_i) begin
      pending_q <= bus.duty_i;
      busy_q    <= 1'b1;
    end else if (step_c && (&done_c)) begin
      busy_q    <= 1'b0;
    end
  end

  // One compare/fade slice per channel.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    pwm_led_channel #(
      .RES       (RES),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cnt_i     (cnt_q),
      .gate_i    (gate_c),
      .step_i    (step_c),
      .pending_i (pending_q[k*RES +: RES]),
      .on_o      (on_c[k]),
      .done_o    (done_c[k])
    );
  end

  assign bus.busy_o = busy_q;
  assign bus.sync_o = sync_q;
  assign bus.half_o = half_q;
  assign bus.led_o  = on_c ^ {CH{bus.an_i}};

endmodule

// File: tb/tb_pwm_led_array.sv
// Directed bench for pwm_led_array (CH=3, RES=8). LED on-time is counted
// over windows aligned to the registered compare (cnt=1 .. next cnt=0).
module tb_pwm_led_array;
  import pwm_led_pkg::*;

  localparam int unsigned CH        = 3;
  localparam int unsigned RES       = 8;
  localparam int unsigned FADE_STEP = 16;
  localparam int          PER       = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_led_array_if #(.CH(CH), .RES(RES)) bus ();

  pwm_led_array #(
    .CH        (CH),
    .RES       (RES),
    .FADE_STEP (FADE_STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int on_cnt [CH];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Advance to a negedge inside the cnt==0 cycle.
  task automatic wait_sync(input string tag);
    for (int i = 0; i < 2*PER && bus.sync_o !== 1'b1; i++) @(negedge clk);
    check_eq({tag, "_sync"}, 64'(bus.sync_o), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20*PER && bus.busy_o !== 1'b0; i++) @(negedge clk);
    check_eq({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
  endtask

  // Count led_o high samples over one compare-aligned period.
  task automatic measure(input string tag);
    wait_sync(tag);
    @(negedge clk);
    for (int k = 0; k < CH; k++) on_cnt[k] = 0;
    repeat (PER) begin
      for (int k = 0; k < CH; k++) if (bus.led_o[k] === 1'b1) on_cnt[k]++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_update(input logic [CH*RES-1:0] d);
    bus.duty_i   = d;
    bus.update_i = 1'b1;
    @(negedge clk);
    bus.update_i = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int e0, input int e1, input int e2);
    check_eq({tag, "_ch0"}, 64'(on_cnt[0]), 64'(e0));
    check_eq({tag, "_ch1"}, 64'(on_cnt[1]), 64'(e1));
    check_eq({tag, "_ch2"}, 64'(on_cnt[2]), 64'(e2));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int full_p;
    int part_p;
    int total;

    bus.an_i         = 1'b1;
    bus.duty_i       = '0;
    bus.update_i     = 1'b0;
    bus.brightness_i = 3'd7;
    rst              = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state with common-anode polarity.
    check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
    check_eq("rst_sync", 64'(bus.sync_o), 64'd1);
    check_eq("rst_half", 64'(bus.half_o), 64'd0);
    check_eq("rst_led_an", 64'(bus.led_o), 64'b111);
    bus.an_i = 1'b0;
    #1;
    check_eq("rst_led_cc", 64'(bus.led_o), 64'b000);

    @(negedge clk);
    rst = 1'b1;

    // half_o follows the counter MSB.
    wait_sync("half");
    repeat (127) @(negedge clk);
    check_eq("half_127", 64'(bus.half_o), 64'd0);
    @(negedge clk);
    check_eq("half_128", 64'(bus.half_o), 64'd1);

    // Duties 0 / 0x80 / 0xFF.
    pulse_update({8'hFF, 8'h80, 8'h00});
    check_eq("upd_busy", 64'(bus.busy_o), 64'd1);
    wait_idle("duty");
    measure("duty");
    check_counts("duty", 0, 128, 256);

    // Common anode inverts the pins.
    bus.an_i = 1'b1;
    measure("anode");
    check_counts("anode", 256, 128, 0);
    bus.an_i = 1'b0;

`ifndef PWM_LED_ARRAY_FADE_EN
    // Two strobes in one period: only the latest reaches the outputs.
    wait_sync("ovr");
    repeat (10) @(negedge clk);
    pulse_update({8'h40, 8'h40, 8'h40});
    check_eq("ovr_busy_a", 64'(bus.busy_o), 64'd1);
    repeat (189) @(negedge clk);
    pulse_update({8'hC0, 8'h08, 8'h20});
    check_eq("ovr_busy_b", 64'(bus.busy_o), 64'd1);
    repeat (54) @(negedge clk);
    check_eq("ovr_busy_255", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    check_eq("ovr_wrap_sync", 64'(bus.sync_o), 64'd1);
    check_eq("ovr_wrap_busy", 64'(bus.busy_o), 64'd0);
    measure("ovr");
    check_counts("ovr", 32, 8, 192);

    // Strobe on a wrap edge is deferred by one full period.
    wait_sync("wrp");
    repeat (255) @(negedge clk);
    pulse_update({8'h01, 8'h02, 8'h03});
    check_eq("wrp_busy0", 64'(bus.busy_o), 64'd1);
    measure("wrp_old");
    check_counts("wrp_old", 32, 8, 192);
    check_eq("wrp_busy1", 64'(bus.busy_o), 64'd0);
    measure("wrp_new");
    check_counts("wrp_new", 3, 2, 1);
`endif

    // Brightness 1: full duty for 2 of every 8 periods.
    bus.brightness_i = 3'd1;
    pulse_update({8'hFF, 8'hFF, 8'hFF});
    wait_idle("bri");
    full_p = 0;
    part_p = 0;
    total  = 0;
    for (int p = 0; p < 8; p++) begin
      measure("bri");
      total += on_cnt[0];
      if (on_cnt[0] == PER) full_p++;
      else if (on_cnt[0] != 0) part_p++;
    end
    check_eq("bri_full", 64'(full_p), 64'd2);
    check_eq("bri_part", 64'(part_p), 64'd0);
    check_eq("bri_total", 64'(total), 64'd512);
    bus.brightness_i = 3'd7;

    // Reset mid-period with an update pending.
    wait_sync("rst2");
    repeat (150) @(negedge clk);
    pulse_update({8'h11, 8'h22, 8'h33});
    check_eq("rst2_pre_busy", 64'(bus.busy_o), 64'd1);
    check_eq("rst2_pre_half", 64'(bus.half_o), 64'd1);
    check_eq("rst2_pre_led", 64'(bus.led_o), 64'b111);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst2_busy", 64'(bus.busy_o), 64'd0);
    check_eq("rst2_sync", 64'(bus.sync_o), 64'd1);
    check_eq("rst2_half", 64'(bus.half_o), 64'd0);
    check_eq("rst2_led", 64'(bus.led_o), 64'b000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_eq("rel_sync0", 64'(bus.sync_o), 64'd1);
    repeat (255) @(negedge clk);
    check_eq("rel_sync255", 64'(bus.sync_o), 64'd0);
    check_eq("rel_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    check_eq("rel_sync256", 64'(bus.sync_o), 64'd1);
    measure("rel");
    check_counts("rel", 0, 0, 0);

`ifdef PWM_LED_ARRAY_FADE_EN
    // Fade 0 -> 0x40 in steps of 16.
    pulse_update({8'h40, 8'h40, 8'h40});
    for (int i = 1; i <= 4; i++) begin
      wait_sync("fade");
      check_eq($sformatf("fade_busy_%0d", i), 64'(bus.busy_o), 64'(i < 4));
      measure("fade");
      check_eq($sformatf("fade_duty_%0d", i), 64'(on_cnt[0]), 64'(16 * i));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
